// File: rtl/decode_ex_pipe.sv
// decode_ex_pipe: single registered stage that decodes a 5-bit-opcode instruction,
// resolves control flow (JR/JPC/BRFL/CALL/RET) with an internal return-address
// stack, and hands a decoded bundle downstream over a valid/ready handshake.
module decode_ex_pipe #(
    parameter int PC_W      = 32,
    parameter int IMM_W     = 32,
    parameter int RAS_DEPTH = 4,
    parameter int SHADOW    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [3:0]       in_flags,
    input  logic [PC_W-1:0]  jr_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_ula_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rb,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_en_lw,
    output logic             out_en_sw,
    output logic [PC_W-1:0]  out_pc_next,
    output logic             out_redirect,
    output logic             out_illegal,
    output logic             ras_overflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [4:0] OP_LW   = 5'd0;
    localparam logic [4:0] OP_SW   = 5'd1;
    localparam logic [4:0] OP_MOV  = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_MUL  = 5'd5;
    localparam logic [4:0] OP_DIV  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_SHR  = 5'd10;
    localparam logic [4:0] OP_CMP  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;
    localparam logic [4:0] OP_JR   = 5'd13;
    localparam logic [4:0] OP_JPC  = 5'd14;
    localparam logic [4:0] OP_BRFL = 5'd15;
    localparam logic [4:0] OP_CALL = 5'd16;
    localparam logic [4:0] OP_RET  = 5'd17;
    localparam logic [4:0] OP_NOP  = 5'd18;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;   // next push slot; when full it is also the oldest entry
    logic [CNT_W-1:0] ras_cnt;
    logic [2:0]       shadow_cnt;

    logic [4:0]        op;
    logic signed [16:0] imm17;
    logic [PC_W-1:0]   pc_inc;
    logic [PTR_W-1:0]  ras_top;
    logic              accept;
    logic              forward;

    logic [3:0]        d_ula_op;
    logic              d_en_lw;
    logic              d_en_sw;
    logic [PC_W-1:0]   d_pc_next;
    logic              d_redirect;
    logic              d_illegal;
    logic              d_push;
    logic              d_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
    endfunction

    assign op       = in_instr[31:27];
    assign imm17    = in_instr[16:0];
    assign pc_inc   = in_pc + 1'b1;
    assign ras_top  = ptr_dec(ras_ptr);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // Wrong-path instructions behind a redirect are swallowed, not forwarded
    assign forward  = accept && (shadow_cnt == 3'd0);

    // Decode opcode and resolve the next fetch address
    always_comb begin
        d_ula_op   = 4'hF;
        d_en_lw    = 1'b0;
        d_en_sw    = 1'b0;
        d_pc_next  = pc_inc;
        d_redirect = 1'b0;
        d_illegal  = 1'b0;
        d_push     = 1'b0;
        d_pop      = 1'b0;
        case (op)
            OP_LW:   d_en_lw = 1'b1;
            OP_SW:   d_en_sw = 1'b1;
            OP_MOV:  d_ula_op = 4'h0;
            OP_ADD:  d_ula_op = 4'h1;
            OP_SUB:  d_ula_op = 4'h2;
            OP_MUL:  d_ula_op = 4'h3;
            OP_DIV:  d_ula_op = 4'h4;
            OP_AND:  d_ula_op = 4'h5;
            OP_OR:   d_ula_op = 4'h6;
            OP_SHL:  d_ula_op = 4'h7;
            OP_SHR:  d_ula_op = 4'h8;
            OP_CMP:  d_ula_op = 4'h9;
            OP_NOT:  d_ula_op = 4'hA;
            OP_JR: begin
                d_pc_next  = jr_target;
                d_redirect = 1'b1;
            end
            OP_JPC: begin
                d_pc_next  = in_pc + PC_W'(imm17);
                d_redirect = 1'b1;
            end
            OP_BRFL: begin
                if (|(in_flags & in_instr[26:23])) begin
                    d_pc_next  = in_pc + PC_W'(imm17);
                    d_redirect = 1'b1;
                end
            end
            OP_CALL: begin
                d_push     = 1'b1;
                d_pc_next  = PC_W'(in_instr[26:0]);
                d_redirect = 1'b1;
            end
            OP_RET: begin
                if (ras_cnt != '0) begin
                    d_pop      = 1'b1;
                    d_pc_next  = ras_mem[ras_top];
                    d_redirect = 1'b1;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_NOP:  ;
            default: d_illegal = 1'b1;
        endcase
    end

    // Output bundle register: load on forward, clear valid once drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_ula_op   <= '0;
            out_rd       <= '0;
            out_rs       <= '0;
            out_rb       <= '0;
            out_imm      <= '0;
            out_en_lw    <= 1'b0;
            out_en_sw    <= 1'b0;
            out_pc_next  <= '0;
            out_redirect <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (forward) begin
            out_valid    <= 1'b1;
            out_ula_op   <= d_ula_op;
            out_rd       <= in_instr[26:22];
            out_rs       <= in_instr[21:17];
            out_rb       <= in_instr[16:12];
            out_imm      <= IMM_W'(imm17);
            out_en_lw    <= d_en_lw;
            out_en_sw    <= d_en_sw;
            out_pc_next  <= d_pc_next;
            out_redirect <= d_redirect;
            out_illegal  <= d_illegal;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Shadow counter: arm after a forwarded redirect, count down on dropped instructions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_cnt <= 3'd0;
        end else if (forward && d_redirect) begin
            shadow_cnt <= 3'(SHADOW);
        end else if (accept && shadow_cnt != 3'd0) begin
            shadow_cnt <= shadow_cnt - 3'd1;
        end
    end

    // RAS pointer/count bookkeeping; a push into a full stack overwrites the oldest entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr      <= '0;
            ras_cnt      <= '0;
            ras_overflow <= 1'b0;
        end else if (forward && d_push) begin
            ras_ptr <= ptr_inc(ras_ptr);
            if (ras_cnt == CNT_W'(RAS_DEPTH)) begin
                ras_overflow <= 1'b1;
            end else begin
                ras_cnt <= ras_cnt + 1'b1;
            end
        end else if (forward && d_pop) begin
            ras_ptr <= ras_top;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    // RAS storage holds return addresses only; validity is tracked by ras_cnt
    always_ff @(posedge clk) begin
        if (forward && d_push) begin
            ras_mem[ras_ptr] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_decode_ex_pipe.sv
// Randomised and directed bench for decode_ex_pipe with a queue-based reference model.
module tb_decode_ex_pipe;

    localparam int PC_W      = 32;
    localparam int IMM_W     = 32;
    localparam int RAS_DEPTH = 4;
    localparam int SHADOW    = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic [3:0]       in_flags;
    logic [PC_W-1:0]  jr_target;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_ula_op;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs;
    logic [4:0]       out_rb;
    logic [IMM_W-1:0] out_imm;
    logic             out_en_lw;
    logic             out_en_sw;
    logic [PC_W-1:0]  out_pc_next;
    logic             out_redirect;
    logic             out_illegal;
    logic             ras_overflow;

    decode_ex_pipe #(
        .PC_W(PC_W), .IMM_W(IMM_W), .RAS_DEPTH(RAS_DEPTH), .SHADOW(SHADOW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_flags(in_flags), .jr_target(jr_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_ula_op(out_ula_op),
        .out_rd(out_rd), .out_rs(out_rs), .out_rb(out_rb), .out_imm(out_imm),
        .out_en_lw(out_en_lw), .out_en_sw(out_en_sw), .out_pc_next(out_pc_next),
        .out_redirect(out_redirect), .out_illegal(out_illegal), .ras_overflow(ras_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic            m_valid;
    logic [3:0]      m_ula_op;
    logic [4:0]      m_rd, m_rs, m_rb;
    logic [31:0]     m_imm;
    logic            m_lw, m_sw;
    logic [31:0]     m_pc_next;
    logic            m_redirect, m_illegal;
    logic            m_ovf;
    int              m_shadow;
    logic [31:0]     m_ras[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ula_op = 0; m_rd = 0; m_rs = 0; m_rb = 0; m_imm = 0;
        m_lw = 0; m_sw = 0; m_pc_next = 0; m_redirect = 0; m_illegal = 0;
        m_ovf = 0; m_shadow = 0; m_ras.delete();
    endtask

    // Advance the model by one clock edge given the inputs currently applied
    task automatic model_step();
        logic [4:0]  op;
        logic [31:0] sx;
        logic        acc;
        acc = in_valid && (!m_valid || out_ready);
        if (!acc) begin
            if (out_ready) m_valid = 0;
            return;
        end
        if (m_shadow != 0) begin
            m_shadow--;
            m_valid = 0;
            return;
        end
        op = in_instr[31:27];
        sx = {{15{in_instr[16]}}, in_instr[16:0]};
        m_valid = 1;
        m_rd = in_instr[26:22]; m_rs = in_instr[21:17]; m_rb = in_instr[16:12];
        m_imm = sx;
        m_lw = (op == 0);
        m_sw = (op == 1);
        m_ula_op = (op >= 2 && op <= 12) ? 4'(op - 2) : 4'hF;
        m_pc_next = in_pc + 1;
        m_redirect = 0;
        m_illegal = (op > 18);
        if (op == 13) begin
            m_pc_next = jr_target; m_redirect = 1;
        end else if (op == 14 || (op == 15 && (in_flags & in_instr[26:23]) != 0)) begin
            m_pc_next = in_pc + sx; m_redirect = 1;
        end else if (op == 16) begin
            m_ras.push_back(in_pc + 1);
            if (m_ras.size() > RAS_DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1;
            end
            m_pc_next = {5'd0, in_instr[26:0]}; m_redirect = 1;
        end else if (op == 17) begin
            if (m_ras.size() > 0) begin
                m_pc_next = m_ras.pop_back(); m_redirect = 1;
            end else begin
                m_illegal = 1;
            end
        end
        if (m_redirect) m_shadow = SHADOW;
    endtask

    // Compare DUT outputs with the model (called away from the clock edge)
    task automatic compare();
        chk("out_valid", out_valid, m_valid);
        chk("ras_overflow", ras_overflow, m_ovf);
        if (m_valid) begin
            chk("ula_op", out_ula_op, m_ula_op);
            chk("rd", out_rd, m_rd);
            chk("rs", out_rs, m_rs);
            chk("rb", out_rb, m_rb);
            chk("imm", out_imm, m_imm);
            chk("en_lw", out_en_lw, m_lw);
            chk("en_sw", out_en_sw, m_sw);
            chk("pc_next", out_pc_next, m_pc_next);
            chk("redirect", out_redirect, m_redirect);
            chk("illegal", out_illegal, m_illegal);
        end
    endtask

    // One clock: apply inputs at the negedge, check in_ready, step model, compare after edge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [3:0] fl, input logic [31:0] jt, input logic rdy);
        in_valid = v; in_instr = ins; in_pc = pc; in_flags = fl; jr_target = jt; out_ready = rdy;
        #1;
        chk("in_ready", in_ready, !m_valid || rdy);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ras_overflow", ras_overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [26:0] rest);
        return {op, rest};
    endfunction

    localparam logic [31:0] NOP_I = {5'd18, 27'd0};
    localparam logic [31:0] RET_I = {5'd17, 27'd0};

    initial begin
        logic [31:0] exp_ret [4];
        logic [31:0] held_pc;
        exp_ret[0] = 32'd10; exp_ret[1] = 32'd9; exp_ret[2] = 32'd8; exp_ret[3] = 32'd7;
        reset = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; in_flags = 0; jr_target = 0; out_ready = 1;
        model_reset();
        #2;
        chk("reset_valid", out_valid, 0);
        chk("reset_pc_next", out_pc_next, 0);
        chk("reset_ula_op", out_ula_op, 0);
        chk("reset_imm", out_imm, 0);
        chk("reset_illegal", out_illegal, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ADD rd=1 rs=2 imm=1 at pc 10
        cycle(1, mk(5'd3, {5'd1, 5'd2, 17'd1}), 32'd10, 0, 0, 1);
        chk("add_valid", out_valid, 1);
        chk("add_ula", out_ula_op, 4'd1);
        chk("add_rd", out_rd, 5'd1);
        chk("add_rs", out_rs, 5'd2);
        chk("add_imm", out_imm, 32'd1);
        chk("add_pc_next", out_pc_next, 32'd11);
        chk("add_redirect", out_redirect, 0);

        // JPC -4 at pc 20, then a wrong-path ADD is dropped, the next is forwarded
        cycle(1, mk(5'd14, {10'd0, 17'h1FFFC}), 32'd20, 0, 0, 1);
        chk("jpc_pc_next", out_pc_next, 32'd16);
        chk("jpc_redirect", out_redirect, 1);
        cycle(1, mk(5'd3, {5'd1, 5'd2, 17'd1}), 32'd21, 0, 0, 1);
        chk("shadow_drop", out_valid, 0);
        cycle(1, mk(5'd3, {5'd3, 5'd4, 17'd1}), 32'd16, 0, 0, 1);
        chk("after_shadow_valid", out_valid, 1);
        chk("after_shadow_pc", out_pc_next, 32'd17);

        // BRFL taken / not taken
        cycle(1, mk(5'd15, {4'b0100, 1'b0, 5'd0, 17'd8}), 32'd30, 4'b0100, 0, 1);
        chk("brfl_taken_pc", out_pc_next, 32'd38);
        chk("brfl_taken_redir", out_redirect, 1);
        cycle(1, NOP_I, 32'd31, 0, 0, 1);
        cycle(1, mk(5'd15, {4'b0100, 1'b0, 5'd0, 17'd8}), 32'd40, 4'b1011, 0, 1);
        chk("brfl_nt_pc", out_pc_next, 32'd41);
        chk("brfl_nt_redir", out_redirect, 0);

        // Five CALLs into a depth-4 RAS, then five RETs
        for (int i = 0; i < 5; i++) begin
            cycle(1, mk(5'd16, 27'd100), 32'(5 + i), 0, 0, 1);
            cycle(1, NOP_I, 32'd101, 0, 0, 1);
        end
        chk("ovf_set", ras_overflow, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, RET_I, 32'd200, 0, 0, 1);
            chk("ret_pc", out_pc_next, exp_ret[i]);
            chk("ret_redirect", out_redirect, 1);
            cycle(1, NOP_I, 32'd201, 0, 0, 1);
        end
        cycle(1, RET_I, 32'd300, 0, 0, 1);
        chk("ret_empty_illegal", out_illegal, 1);
        chk("ret_empty_pc", out_pc_next, 32'd301);
        chk("ret_empty_redir", out_redirect, 0);

        // Backpressure: bundle held, in_ready low, then one per cycle
        cycle(1, mk(5'd4, {5'd7, 5'd8, 17'd5}), 32'd50, 0, 0, 0);
        held_pc = out_pc_next;
        for (int i = 0; i < 3; i++) begin
            cycle(1, mk(5'd16, 27'd77), 32'd60, 0, 0, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_pc", out_pc_next, held_pc);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1, mk(5'd7, {5'd1, 5'd1, 17'd0}), 32'(70 + i), 0, 0, 1);
            chk("bp_release_valid", out_valid, 1);
        end

        // Reset in the middle of a stream after two CALLs
        do_reset();
        cycle(1, mk(5'd16, 27'd500), 32'd1, 0, 0, 1);
        cycle(1, NOP_I, 32'd2, 0, 0, 1);
        cycle(1, mk(5'd16, 27'd600), 32'd501, 0, 0, 1);
        do_reset();
        chk("midrst_valid", out_valid, 0);
        cycle(1, RET_I, 32'd40, 0, 0, 1);
        chk("midrst_ret_illegal", out_illegal, 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            int          sel;
            ins = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 2)      ins[31:27] = 5'd16;
            else if (sel < 4) ins[31:27] = 5'd17;
            else if (sel < 5) ins[31:27] = 5'(13 + $urandom_range(0, 2));
            cycle($urandom_range(0, 3) != 0, ins, $urandom, 4'($urandom), $urandom,
                  $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
